// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser
//   Byte-level command decoder between a UART receiver and transmitter.
//   Frames 5-byte packets (0xA5, CMD, ADDR, DATA, CHK with CHK = CMD^ADDR^DATA),
//   writes or reads an internal bank of 8-bit registers, and answers each
//   packet with ACK (0x06) or NAK (0x15), followed by one data byte on reads.
// Ports
//   clk        system clock, all logic on posedge
//   rst        asynchronous active-high reset
//   rx_valid   one-cycle strobe qualifying rx_data
//   rx_data    received byte
//   tx_busy    transmitter busy, high while a byte shifts out
//   tx_start   one-cycle start pulse to the transmitter
//   tx_data    byte to send; valid with tx_start and held until the next start
//   gp_in      general-purpose inputs, readable at address 0xFF
//   reg_out    register bank, register k at bits [8k+7:8k]
//   err_count  saturating count of NAKs plus inter-byte timeouts
module uart_cmd_parser #(
  parameter int NUM_REGS    = 4,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  input  logic                  tx_busy,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  input  logic [7:0]            gp_in,
  output logic [8*NUM_REGS-1:0] reg_out,
  output logic [7:0]            err_count
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0] SYNC_B = 8'hA5;
  localparam logic [7:0] CMD_W  = 8'h57;
  localparam logic [7:0] CMD_R  = 8'h52;
  localparam logic [7:0] ACK_B  = 8'h06;
  localparam logic [7:0] NAK_B  = 8'h15;

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_ADDR, S_DATA, S_CHK, S_EXEC, S_TX1, S_TX1W, S_TX2, S_TX2W
  } state_t;

  state_t         state, stateNext;
  logic [7:0]     cmdByte, addrByte, dataByte, chkByte;
  logic [TW-1:0]  timer;
  logic [7:0]     regBank [NUM_REGS];
  logic [7:0]     errCnt;
  logic [7:0]     replyByte;   // ACK or NAK chosen in EXEC
  logic [7:0]     rdByte;      // second reply byte on reads
  logic           isRead;
  logic           waitFirst;   // first cycle of TXn_W: transmitter has not raised busy yet
  logic [7:0]     txDataReg;
  logic [7:0]     sendByte;
  logic [7:0]     bankRd;
  logic           inFrame, timeout;
  logic           chkOk, addrInBank, doWrite, rdBank, rdGp, nak;

  assign inFrame = (state == S_CMD) || (state == S_ADDR) ||
                   (state == S_DATA) || (state == S_CHK);
  // A byte arriving in the expiry cycle takes precedence over the timeout.
  assign timeout = inFrame && !rx_valid && (timer == TW'(TIMEOUT_CYC - 1));

  // Frame evaluation, consumed only in EXEC
  assign chkOk      = ((cmdByte ^ addrByte ^ dataByte) == chkByte);
  assign addrInBank = ({24'd0, addrByte} < 32'(NUM_REGS));
  assign doWrite    = chkOk && (cmdByte == CMD_W) && addrInBank;
  assign rdBank     = chkOk && (cmdByte == CMD_R) && addrInBank;
  assign rdGp       = chkOk && (cmdByte == CMD_R) && (addrByte == 8'hFF);
  assign nak        = !(doWrite || rdBank || rdGp);

  always_comb begin
    bankRd = '0;
    for (int k = 0; k < NUM_REGS; k++)
      if (addrByte == 8'(k)) bankRd = regBank[k];
  end

  always_comb begin
    reg_out = '0;
    for (int k = 0; k < NUM_REGS; k++)
      reg_out[8*k +: 8] = regBank[k];
  end

  assign err_count = errCnt;

  always_comb begin
    stateNext = state;
    tx_start  = 1'b0;
    sendByte  = replyByte;
    case (state)
      S_IDLE: if (rx_valid && rx_data == SYNC_B) stateNext = S_CMD;
      S_CMD:  if (rx_valid) stateNext = S_ADDR; else if (timeout) stateNext = S_IDLE;
      S_ADDR: if (rx_valid) stateNext = S_DATA; else if (timeout) stateNext = S_IDLE;
      S_DATA: if (rx_valid) stateNext = S_CHK;  else if (timeout) stateNext = S_IDLE;
      S_CHK:  if (rx_valid) stateNext = S_EXEC; else if (timeout) stateNext = S_IDLE;
      S_EXEC: stateNext = S_TX1;
      S_TX1: begin
        if (!tx_busy) begin
          tx_start  = 1'b1;
          stateNext = S_TX1W;
        end
      end
      S_TX1W: if (!waitFirst && !tx_busy) stateNext = isRead ? S_TX2 : S_IDLE;
      S_TX2: begin
        sendByte = rdByte;
        if (!tx_busy) begin
          tx_start  = 1'b1;
          stateNext = S_TX2W;
        end
      end
      S_TX2W: if (!waitFirst && !tx_busy) stateNext = S_IDLE;
      default: stateNext = S_IDLE;
    endcase
  end

  // Presents the outgoing byte in the start cycle, then holds it
  assign tx_data = tx_start ? sendByte : txDataReg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= stateNext;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmdByte   <= '0;
      addrByte  <= '0;
      dataByte  <= '0;
      chkByte   <= '0;
      timer     <= '0;
      errCnt    <= '0;
      replyByte <= '0;
      rdByte    <= '0;
      isRead    <= 1'b0;
      waitFirst <= 1'b0;
      txDataReg <= '0;
      for (int k = 0; k < NUM_REGS; k++) regBank[k] <= '0;
    end else begin
      waitFirst <= tx_start;
      if (tx_start) txDataReg <= sendByte;

      if (inFrame && !rx_valid) timer <= timer + TW'(1);
      else                      timer <= '0;

      if (timeout && errCnt != 8'hFF) errCnt <= errCnt + 8'd1;

      case (state)
        S_CMD:  if (rx_valid) cmdByte  <= rx_data;
        S_ADDR: if (rx_valid) addrByte <= rx_data;
        S_DATA: if (rx_valid) dataByte <= rx_data;
        S_CHK:  if (rx_valid) chkByte  <= rx_data;
        S_EXEC: begin
          replyByte <= nak ? NAK_B : ACK_B;
          isRead    <= rdBank || rdGp;
          rdByte    <= rdGp ? gp_in : bankRd;
          if (nak && errCnt != 8'hFF) errCnt <= errCnt + 8'd1;
          for (int k = 0; k < NUM_REGS; k++)
            if (doWrite && addrByte == 8'(k)) regBank[k] <= dataByte;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Randomised scoreboard bench for uart_cmd_parser with a packet-level
// reference model and a simple transmitter busy model.
module tb_uart_cmd_parser;

  localparam int NR = 4;
  localparam int TO = 40;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          tx_busy = 1'b0;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic [7:0]    gp_in = '0;
  logic [8*NR-1:0] reg_out;
  logic [7:0]    err_count;

  uart_cmd_parser #(.NUM_REGS(NR), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
    .gp_in(gp_in), .reg_out(reg_out), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int startCount = 0;
  int busyHandled = 0;
  int forceLen = 0;
  logic [7:0] lastData = '0;
  logic [7:0] expQ[$];
  int startCycles[$];

  // reference model state
  logic [7:0] mRegs [NR];
  int mErr = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: pops the scoreboard whenever the DUT starts a byte
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (tx_start) begin
        logic [7:0] e;
        startCount++;
        startCycles.push_back(cyc);
        checks++;
        if (tx_busy) begin
          failures++;
          $display("FAIL start_while_busy got tx_busy=%0b need 0", tx_busy);
        end
        checks++;
        if (expQ.size() == 0) begin
          failures++;
          $display("FAIL unexpected_reply got %02h need none", tx_data);
        end else begin
          e = expQ.pop_front();
          if (tx_data !== e) begin
            failures++;
            $display("FAIL reply_byte got %02h need %02h", tx_data, e);
          end
        end
        lastData = tx_data;
      end else if (tx_busy) begin
        checks++;
        if (tx_data !== lastData) begin
          failures++;
          $display("FAIL tx_data_hold got %02h need %02h", tx_data, lastData);
        end
      end
    end
  end

  // Transmitter model: busy rises the cycle after each start
  initial begin
    int left;
    left = 0;
    forever begin
      @(posedge clk);
      #2;
      if (busyHandled != startCount) begin
        busyHandled = startCount;
        left = (forceLen > 0) ? forceLen : int'($urandom_range(2, 6));
        tx_busy = 1'b1;
      end else if (left > 0) begin
        left--;
        if (left == 0) tx_busy = 1'b0;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got running need finished");
    $fatal(1, "watchdog");
  end

  task automatic sendByte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    for (int i = 0; i < gap; i++) begin @(posedge clk); #1; end
  endtask

  // Packet-level expectation from the command rules
  task automatic modelFrame(input logic [7:0] c, a, d, k);
    if ((c ^ a ^ d) != k) begin
      expQ.push_back(8'h15); if (mErr < 255) mErr++;
    end else if (c == 8'h57 && a < NR) begin
      mRegs[a] = d; expQ.push_back(8'h06);
    end else if (c == 8'h52 && a < NR) begin
      expQ.push_back(8'h06); expQ.push_back(mRegs[a]);
    end else if (c == 8'h52 && a == 8'hFF) begin
      expQ.push_back(8'h06); expQ.push_back(gp_in);
    end else begin
      expQ.push_back(8'h15); if (mErr < 255) mErr++;
    end
  endtask

  task automatic sendFrame(input logic [7:0] c, a, d, k, input logic junkAfter);
    sendByte(8'hA5, $urandom_range(0, 3));
    sendByte(c, $urandom_range(0, 3));
    sendByte(a, $urandom_range(0, 3));
    sendByte(d, $urandom_range(0, 3));
    modelFrame(c, a, d, k);
    sendByte(k, 0);
    if (junkAfter) sendByte(8'hA5, 0);
  endtask

  task automatic waitQuiet();
    int n;
    n = 0;
    while ((expQ.size() != 0 || tx_busy || busyHandled != startCount) && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n >= 3000) begin
      failures++;
      $display("FAIL reply_timeout got pending=%0d need 0", expQ.size());
      expQ.delete();
    end
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic checkState(input string tag);
    logic [8*NR-1:0] want;
    for (int k = 0; k < NR; k++) want[8*k +: 8] = mRegs[k];
    checks++;
    if (reg_out !== want) begin
      failures++;
      $display("FAIL %s reg_out got %h need %h", tag, reg_out, want);
    end
    checks++;
    if (err_count !== 8'(mErr)) begin
      failures++;
      $display("FAIL %s err_count got %0d need %0d", tag, err_count, mErr);
    end
  endtask

  task automatic checkZero(input string tag);
    checks++;
    if (tx_start !== 1'b0 || tx_data !== 8'h00 || reg_out !== '0 || err_count !== 8'h00) begin
      failures++;
      $display("FAIL %s got start=%0b data=%02h regs=%h err=%0d need all zero",
               tag, tx_start, tx_data, reg_out, err_count);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    #1;
    checkZero("reset_async");
    repeat (2) begin @(posedge clk); #1; end
    checkZero("reset_hold");
    rst = 1'b0;
    for (int k = 0; k < NR; k++) mRegs[k] = '0;
    mErr = 0;
    expQ.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] c, a, d, k;
    int gapCyc;
    for (int i = 0; i < NR; i++) mRegs[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    doReset();

    // 1: write then read back
    sendFrame(8'h57, 8'h02, 8'h3C, 8'h69, 1'b0); waitQuiet();
    sendFrame(8'h52, 8'h02, 8'h00, 8'h50, 1'b0); waitQuiet();
    checkState("t1");

    // 2: bad checksum
    sendFrame(8'h57, 8'h01, 8'h55, 8'h00, 1'b0); waitQuiet();
    checkState("t2");

    // 3a: idle for TO-1 cycles between bytes is still tolerated
    sendByte(8'hA5, 0); sendByte(8'h57, 0); sendByte(8'h01, TO - 1);
    sendByte(8'h22, 0);
    modelFrame(8'h57, 8'h01, 8'h22, 8'h57 ^ 8'h01 ^ 8'h22);
    sendByte(8'h57 ^ 8'h01 ^ 8'h22, 0);
    waitQuiet();
    checkState("t3_edge");

    // 3b: TO idle cycles abort the frame silently
    sendByte(8'hA5, 0); sendByte(8'h57, 0); sendByte(8'h01, TO + 5);
    if (mErr < 255) mErr++;
    checkState("t3_timeout");
    sendFrame(8'h57, 8'h01, 8'h11, 8'h47, 1'b0); waitQuiet();
    checkState("t3");

    // 4: gp read with a long-busy transmitter
    gp_in = 8'hC3;
    forceLen = 50;
    startCycles.delete();
    sendFrame(8'h52, 8'hFF, 8'h00, 8'hAD, 1'b0); waitQuiet();
    forceLen = 0;
    checks++;
    if (startCycles.size() != 2 || (startCycles[1] - startCycles[0]) < 51) begin
      failures++;
      $display("FAIL t4_gap got starts=%0d gap=%0d need 2 and >=51", startCycles.size(),
               (startCycles.size() == 2) ? startCycles[1] - startCycles[0] : -1);
    end

    // 5: noise before a valid frame
    sendByte(8'h00, 1); sendByte(8'hFF, 1); sendByte(8'h12, 1);
    sendFrame(8'h57, 8'h03, 8'h9E, 8'h57 ^ 8'h03 ^ 8'h9E, 1'b0); waitQuiet();
    checkState("t5");

    // 6: reset mid-frame
    sendByte(8'hA5, 0); sendByte(8'h57, 0); sendByte(8'h00, 0);
    doReset();
    checkState("t6_reset");
    sendFrame(8'h57, 8'h00, 8'h7B, 8'h57 ^ 8'h00 ^ 8'h7B, 1'b0); waitQuiet();
    checkState("t6");

    // Random frames, occasionally with a sync byte arriving during the reply
    for (int n = 0; n < 40; n++) begin
      gp_in = 8'($urandom);
      case ($urandom_range(0, 3))
        0: c = 8'h57;
        1: c = 8'h52;
        2: c = 8'h52;
        default: c = 8'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0: a = 8'hFF;
        1: a = 8'($urandom);
        default: a = 8'($urandom_range(0, NR - 1));
      endcase
      d = 8'($urandom);
      k = c ^ a ^ d;
      if ($urandom_range(0, 4) == 0) k = k ^ 8'($urandom_range(1, 255));
      if ($urandom_range(0, 3) == 0) begin
        gapCyc = $urandom_range(0, 2);
        sendByte(8'($urandom_range(0, 164)), gapCyc);
      end
      sendFrame(c, a, d, k, ($urandom_range(0, 2) == 0));
      waitQuiet();
      checkState("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
